sprite_table_sync: RTL and testbench
====================================

# sprite_table_sync

Parametrised, frame-synchronised successor to the hardware-software sprite port block: the NIOS writes sprite records one at a time over a single 32-bit port with a 2-bit request/acknowledge handshake, and the block drives an NUM_SPRITES-deep table of coordinates, state and type to frame_displayer. With double buffering compiled in, software writes land in a shadow table that is copied to the live table only at the start of vertical sync, so sprites never tear mid-frame. It sits between nios_system PIOs and frame_displayer, clocked by CLOCK_50.

## Interface
- NUM_SPRITES, 10, number of table entries, legal range 1..64
- COORD_W, 10, width of xCoord/yCoord entries
- clk  input  1  system clock (CLOCK_50)
- reset  input  1  asynchronous, active-high reset
- to_hw_data  input  32  sprite record: [9:0] x, [19:10] y, [22:20] state, [25:23] type, [31:26] index
- to_hw_sig  input  2  request code: 00 idle, 01 write, 10 commit, 11 clear
- to_sw_sig  output  2  response code: 00 idle, 01 ack, 10 commit done, 11 error
- frame_vs  input  1  VGA vertical sync, active low, same clock domain
- xCoord  output  NUM_SPRITES x COORD_W  live x per entry
- yCoord  output  NUM_SPRITES x COORD_W  live y per entry
- sprState  output  NUM_SPRITES x 3  live state per entry; 0 = inactive
- sprType  output  NUM_SPRITES x 3  live type per entry
- active_mask  output  NUM_SPRITES  bit i = (sprState[i] != 0), registered
- commit_pending  output  1  high while in WAIT_FRAME

## Operation
- to_hw_sig registered once into sig_q; FSM acts on sig_q only.
- FSM states: IDLE, ACK, WAIT_FRAME.
- IDLE, sig_q=01: index < NUM_SPRITES -> write shadow[index], to_sw_sig<=01; else no write, to_sw_sig<=11. Go ACK.
- IDLE, sig_q=11: zero every shadow entry (and live entries when DBUF disabled), to_sw_sig<=01, go ACK.
- IDLE, sig_q=10: go WAIT_FRAME, commit_pending<=1.
- WAIT_FRAME: on vs_fall (frame_vs registered, 1->0 detected) copy shadow to live in one cycle, to_sw_sig<=10, commit_pending<=0, go ACK. sig_q changes ignored while waiting.
- ACK: hold to_sw_sig until sig_q=00, then to_sw_sig<=00, go IDLE. Other nonzero codes in ACK are ignored (no new transaction without return to 00).
- x/y fields wider than COORD_W truncated to low COORD_W bits; narrower zero-extended.
- active_mask recomputed from live sprState every cycle, one register stage.

## Timing
- Reset (asynchronous, any state): all live and shadow entries 0, active_mask 0, to_sw_sig 00, commit_pending 0, FSM IDLE, sig_q 00, vs history 1.
- Write: to_hw_sig=01 at edge n -> sig_q at n+1 -> shadow write and to_sw_sig=01 at n+2.
- Release: to_hw_sig=00 at edge m -> to_sw_sig=00 at m+2.
- Commit latency: vs_fall detected one cycle after frame_vs falls; live update and to_sw_sig=10 on the following edge; active_mask one cycle later.
- vs_fall coinciding with the IDLE->WAIT_FRAME edge is not taken; commit waits for the next vsync.
- Write and commit never overlap: one transaction per handshake cycle.

## Configuration
- SPRITE_TABLE_DBUF_EN defined: shadow table plus frame-synchronised commit as above.
- Undefined: no shadow storage; writes and clears go straight to live entries; commit (10) acknowledges with 10 two cycles after request without waiting for vsync; commit_pending tied 0; frame_vs unused.

## Structure
- Package sprite_pkg: request/response code enums, record field bit positions, sprite_rec_t struct (x, y, state, type), MAX_SPRITES=64.
- Sub-module vs_edge_detect: registers frame_vs and emits one-cycle vs_fall pulse.
- Top FSM, tables and output flattening in sprite_table_sync.

## Test plan
- Reset mid-WAIT_FRAME -> all outputs 0, to_sw_sig 00, commit_pending 0 immediately, no later commit.
- Write index 3, x=0x1A5, y=0x0F0, state=2, type=5 -> to_sw_sig=01 two cycles later; live unchanged until commit; after next frame_vs fall xCoord[3]=0x1A5, yCoord[3]=0x0F0, active_mask[3]=1, to_sw_sig=10.
- Write index 63 with NUM_SPRITES=10 -> to_sw_sig=11, no entry changes.
- Commit request then toggle to_hw_sig 01 before vsync -> ignored; commit completes at vsync with prior shadow contents.
- Clear (11) after populating entries 0..9 then commit -> all live entries 0, active_mask 0.
- SPRITE_TABLE_DBUF_EN undefined: write index 0 -> xCoord[0] updates with to_sw_sig=01; commit acks 10 without any frame_vs activity.

Source files
------------

// File: rtl/sprite_table_sync_pkg.sv
// Shared types for the sprite table: handshake codes, FSM states and the
// packed 32-bit sprite record layout written by software.
package sprite_pkg;

    localparam int MAX_SPRITES = 64;

    localparam int REC_COORD_W   = 10;
    localparam int REC_STATE_W   = 3;
    localparam int REC_TYPE_W    = 3;
    localparam int REC_INDEX_W   = 6;

    localparam int REC_X_LSB     = 0;
    localparam int REC_Y_LSB     = 10;
    localparam int REC_STATE_LSB = 20;
    localparam int REC_TYPE_LSB  = 23;
    localparam int REC_INDEX_LSB = 26;

    typedef enum logic [1:0] {
        REQ_IDLE   = 2'b00,
        REQ_WRITE  = 2'b01,
        REQ_COMMIT = 2'b10,
        REQ_CLEAR  = 2'b11
    } req_e;

    typedef enum logic [1:0] {
        RSP_IDLE   = 2'b00,
        RSP_ACK    = 2'b01,
        RSP_COMMIT = 2'b10,
        RSP_ERROR  = 2'b11
    } rsp_e;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'b00,
        ST_ACK        = 2'b01,
        ST_WAIT_FRAME = 2'b10
    } fsm_state_e;

    typedef struct packed {
        logic [REC_COORD_W-1:0] x;
        logic [REC_COORD_W-1:0] y;
        logic [REC_STATE_W-1:0] state;
        logic [REC_TYPE_W-1:0]  kind;
    } sprite_rec_t;

    function automatic sprite_rec_t unpack_rec(input logic [31:0] word);
        sprite_rec_t rec;
        rec.x     = word[REC_X_LSB     +: REC_COORD_W];
        rec.y     = word[REC_Y_LSB     +: REC_COORD_W];
        rec.state = word[REC_STATE_LSB +: REC_STATE_W];
        rec.kind  = word[REC_TYPE_LSB  +: REC_TYPE_W];
        return rec;
    endfunction

    function automatic logic [REC_INDEX_W-1:0] rec_index(input logic [31:0] word);
        return word[REC_INDEX_LSB +: REC_INDEX_W];
    endfunction

endpackage

// File: rtl/vs_edge_detect.sv
// Registers the active-low vertical sync and emits a one-cycle pulse the
// cycle after a 1->0 transition is seen.
module vs_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic frame_vs,
    output logic vs_fall
);

    logic vs_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vs_q    <= 1'b1;
            vs_fall <= 1'b0;
        end else begin
            vs_q    <= frame_vs;
            vs_fall <= vs_q & ~frame_vs;
        end
    end

endmodule

// File: rtl/sprite_table_sync.sv
// Sprite table driven by a NIOS request/acknowledge port. Build option
// SPRITE_TABLE_DBUF_EN adds a shadow table committed at vertical sync.
module sprite_table_sync
    import sprite_pkg::*;
#(
    parameter int NUM_SPRITES = 10,
    parameter int COORD_W     = 10
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [31:0]                    to_hw_data,
    input  logic [1:0]                     to_hw_sig,
    output logic [1:0]                     to_sw_sig,
    input  logic                           frame_vs,
    output logic [NUM_SPRITES*COORD_W-1:0] xCoord,
    output logic [NUM_SPRITES*COORD_W-1:0] yCoord,
    output logic [NUM_SPRITES*3-1:0]       sprState,
    output logic [NUM_SPRITES*3-1:0]       sprType,
    output logic [NUM_SPRITES-1:0]         active_mask,
    output logic                           commit_pending
);

    req_e                   sig_q;
    logic [31:0]            data_q;
    fsm_state_e             state_q, state_d;
    rsp_e                   rsp_q, rsp_d;
    logic                   pend_q, pend_d;
    logic                   do_write, do_clear;

    sprite_rec_t            rec;
    logic [REC_INDEX_W-1:0] wr_idx;
    logic                   idx_ok;
    logic [COORD_W-1:0]     wr_x, wr_y;

    logic [COORD_W-1:0]     live_x     [NUM_SPRITES];
    logic [COORD_W-1:0]     live_y     [NUM_SPRITES];
    logic [2:0]             live_state [NUM_SPRITES];
    logic [2:0]             live_type  [NUM_SPRITES];

    // Request code and data are sampled together so a write uses a coherent record.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sig_q  <= REQ_IDLE;
            data_q <= '0;
        end else begin
            sig_q  <= req_e'(to_hw_sig);
            data_q <= to_hw_data;
        end
    end

    assign rec    = unpack_rec(data_q);
    assign wr_idx = rec_index(data_q);
    assign idx_ok = int'(wr_idx) < NUM_SPRITES;
    assign wr_x   = COORD_W'(rec.x);
    assign wr_y   = COORD_W'(rec.y);

`ifdef SPRITE_TABLE_DBUF_EN
    logic vs_fall;
    logic do_commit;

    vs_edge_detect u_vs_edge_detect (
        .clk      (clk),
        .reset    (reset),
        .frame_vs (frame_vs),
        .vs_fall  (vs_fall)
    );
`else
    logic unused_frame_vs;
    assign unused_frame_vs = frame_vs;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            rsp_q   <= RSP_IDLE;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rsp_q   <= rsp_d;
            pend_q  <= pend_d;
        end
    end

    // NOTE: every output of this block gets a default first so no path infers a latch.
    always_comb begin
        state_d   = state_q;
        rsp_d     = rsp_q;
        pend_d    = pend_q;
        do_write  = 1'b0;
        do_clear  = 1'b0;
`ifdef SPRITE_TABLE_DBUF_EN
        do_commit = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                case (sig_q)
                    REQ_WRITE: begin
                        do_write = idx_ok;
                        rsp_d    = idx_ok ? RSP_ACK : RSP_ERROR;
                        state_d  = ST_ACK;
                    end
                    REQ_CLEAR: begin
                        do_clear = 1'b1;
                        rsp_d    = RSP_ACK;
                        state_d  = ST_ACK;
                    end
                    REQ_COMMIT: begin
`ifdef SPRITE_TABLE_DBUF_EN
                        pend_d  = 1'b1;
                        state_d = ST_WAIT_FRAME;
`else
                        rsp_d   = RSP_COMMIT;
                        state_d = ST_ACK;
`endif
                    end
                    default: ;
                endcase
            end
`ifdef SPRITE_TABLE_DBUF_EN
            ST_WAIT_FRAME: begin
                if (vs_fall) begin
                    do_commit = 1'b1;
                    rsp_d     = RSP_COMMIT;
                    pend_d    = 1'b0;
                    state_d   = ST_ACK;
                end
            end
`endif
            ST_ACK: begin
                if (sig_q == REQ_IDLE) begin
                    rsp_d   = RSP_IDLE;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef SPRITE_TABLE_DBUF_EN
    logic [COORD_W-1:0] shadow_x     [NUM_SPRITES];
    logic [COORD_W-1:0] shadow_y     [NUM_SPRITES];
    logic [2:0]         shadow_state [NUM_SPRITES];
    logic [2:0]         shadow_type  [NUM_SPRITES];

    // NOTE: the tables are register arrays, not RAM, so they take the async reset like any other state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset || do_clear) begin
            shadow_x     <= '{default: '0};
            shadow_y     <= '{default: '0};
            shadow_state <= '{default: '0};
            shadow_type  <= '{default: '0};
        end else if (do_write) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                if (wr_idx == REC_INDEX_W'(i)) begin
                    shadow_x[i]     <= wr_x;
                    shadow_y[i]     <= wr_y;
                    shadow_state[i] <= rec.state;
                    shadow_type[i]  <= rec.kind;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            live_x     <= '{default: '0};
            live_y     <= '{default: '0};
            live_state <= '{default: '0};
            live_type  <= '{default: '0};
        end else if (do_commit) begin
            live_x     <= shadow_x;
            live_y     <= shadow_y;
            live_state <= shadow_state;
            live_type  <= shadow_type;
        end
    end
`else
    always_ff @(posedge clk or posedge reset) begin
        if (reset || do_clear) begin
            live_x     <= '{default: '0};
            live_y     <= '{default: '0};
            live_state <= '{default: '0};
            live_type  <= '{default: '0};
        end else if (do_write) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                if (wr_idx == REC_INDEX_W'(i)) begin
                    live_x[i]     <= wr_x;
                    live_y[i]     <= wr_y;
                    live_state[i] <= rec.state;
                    live_type[i]  <= rec.kind;
                end
            end
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_mask <= '0;
        end else begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                active_mask[i] <= (live_state[i] != 3'd0);
            end
        end
    end

    for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_flatten
        assign xCoord[i*COORD_W +: COORD_W] = live_x[i];
        assign yCoord[i*COORD_W +: COORD_W] = live_y[i];
        assign sprState[i*3 +: 3]           = live_state[i];
        assign sprType[i*3 +: 3]            = live_type[i];
    end

    assign to_sw_sig = rsp_q;
`ifdef SPRITE_TABLE_DBUF_EN
    assign commit_pending = pend_q;
`else
    assign commit_pending = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_table_sync.sv
// Randomised bench for sprite_table_sync against a transaction-level table
// model; follows SPRITE_TABLE_DBUF_EN the same way the design does.
module tb_sprite_table_sync;

    localparam int NS = 10;
    localparam int CW = 10;
`ifdef SPRITE_TABLE_DBUF_EN
    localparam bit DBUF = 1'b1;
`else
    localparam bit DBUF = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 reset;
    logic [31:0]          to_hw_data;
    logic [1:0]           to_hw_sig;
    logic [1:0]           to_sw_sig;
    logic                 frame_vs;
    logic [NS*CW-1:0]     xCoord, yCoord;
    logic [NS*3-1:0]      sprState, sprType;
    logic [NS-1:0]        active_mask;
    logic                 commit_pending;

    sprite_table_sync #(.NUM_SPRITES(NS), .COORD_W(CW)) dut (
        .clk            (clk),
        .reset          (reset),
        .to_hw_data     (to_hw_data),
        .to_hw_sig      (to_hw_sig),
        .to_sw_sig      (to_sw_sig),
        .frame_vs       (frame_vs),
        .xCoord         (xCoord),
        .yCoord         (yCoord),
        .sprState       (sprState),
        .sprType        (sprType),
        .active_mask    (active_mask),
        .commit_pending (commit_pending)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model tables: field 0 x, 1 y, 2 state, 3 type.
    int lv [4][NS];
    int sh [4][NS];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] flat(input int f);
        logic [127:0] r = '0;
        int w = (f < 2) ? CW : 3;
        for (int i = 0; i < NS; i++)
            r = r | (128'(lv[f][i] % (1 << w)) << (i * w));
        return r;
    endfunction

    function automatic logic [127:0] exp_mask();
        logic [127:0] r = '0;
        for (int i = 0; i < NS; i++)
            if (lv[2][i] != 0) r = r | (128'(1) << i);
        return r;
    endfunction

    task automatic model_reset();
        for (int f = 0; f < 4; f++)
            for (int i = 0; i < NS; i++) begin
                lv[f][i] = 0;
                sh[f][i] = 0;
            end
    endtask

    task automatic check_live(input string tag);
        check({tag, " x"},     xCoord,   flat(0));
        check({tag, " y"},     yCoord,   flat(1));
        check({tag, " state"}, sprState, flat(2));
        check({tag, " type"},  sprType,  flat(3));
    endtask

    // Waits (bounded) for to_sw_sig to show the wanted code and checks latency in cycles.
    task automatic wait_rsp(input logic [1:0] want, input int exp_lat, input string tag);
        int lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (to_sw_sig === want) begin
                lat = i;
                break;
            end
        end
        check({tag, " rsp"}, to_sw_sig, want);
        if (lat != 0) check({tag, " latency"}, lat, exp_lat);
    endtask

    task automatic release_req(input string tag);
        @(negedge clk);
        to_hw_sig = 2'b00;
        wait_rsp(2'b00, 2, {tag, " release"});
        check({tag, " mask"}, active_mask, exp_mask());
        check({tag, " pending"}, commit_pending, 1'b0);
    endtask

    task automatic write_rec(input int idx, input int x, input int y, input int s, input int t);
        logic [1:0] exp;
        @(negedge clk);
        to_hw_data = 32'((idx << 26) | (t << 23) | (s << 20) | (y << 10) | x);
        to_hw_sig  = 2'b01;
        if (idx < NS) begin
            exp = 2'b01;
            if (DBUF) begin
                sh[0][idx] = x; sh[1][idx] = y; sh[2][idx] = s; sh[3][idx] = t;
            end else begin
                lv[0][idx] = x; lv[1][idx] = y; lv[2][idx] = s; lv[3][idx] = t;
            end
        end else begin
            exp = 2'b11;
        end
        wait_rsp(exp, 2, "write");
        check_live("write");
        release_req("write");
    endtask

    task automatic clear_req();
        @(negedge clk);
        to_hw_sig = 2'b11;
        for (int f = 0; f < 4; f++)
            for (int i = 0; i < NS; i++) begin
                sh[f][i] = 0;
                if (!DBUF) lv[f][i] = 0;
            end
        wait_rsp(2'b01, 2, "clear");
        check_live("clear");
        release_req("clear");
    endtask

    // Drops frame_vs while the design waits, expects the copy and its acknowledge.
    task automatic finish_commit(input string tag);
        logic [127:0] old_mask = exp_mask();
        frame_vs = 1'b0;
        lv = sh;
        wait_rsp(2'b10, 2, {tag, " vsync"});
        check_live({tag, " live"});
        check({tag, " pending clr"}, commit_pending, 1'b0);
        check({tag, " mask lag"}, active_mask, old_mask);
        @(negedge clk);
        check({tag, " mask"}, active_mask, exp_mask());
        frame_vs = 1'b1;
        release_req(tag);
    endtask

    task automatic commit_req(input int wait_cycles, input bit noisy);
        @(negedge clk);
        to_hw_sig = 2'b10;
        if (!DBUF) begin
            wait_rsp(2'b10, 2, "commit direct");
            check_live("commit direct");
            release_req("commit direct");
        end else begin
            repeat (wait_cycles) begin
                @(negedge clk);
                if (noisy) to_hw_sig = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b11;
            end
            check("commit wait rsp", to_sw_sig, 2'b00);
            check("commit wait pending", commit_pending, 1'b1);
            check_live("commit before vsync");
            finish_commit("commit");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        reset      = 1'b1;
        to_hw_sig  = 2'b00;
        to_hw_data = '0;
        frame_vs   = 1'b1;
        #12;
        check("reset rsp", to_sw_sig, 2'b00);
        check("reset pending", commit_pending, 1'b0);
        check("reset mask", active_mask, '0);
        check_live("reset");
        @(negedge clk);
        reset = 1'b0;

        // Directed record from the test plan, then commit it.
        write_rec(3, 'h1A5, 'h0F0, 2, 5);
        commit_req(3, 1'b0);
        check("entry3 active", active_mask[3], 1'b1);

        // Out-of-range index must report an error and change nothing.
        write_rec(63, 'h3FF, 'h3FF, 7, 7);
        commit_req(2, 1'b0);

        // Commit with request noise before vsync.
        write_rec(7, 'h011, 'h222, 1, 3);
        commit_req(5, 1'b1);

        // Populate every entry, commit, clear, commit.
        for (int i = 0; i < NS; i++)
            write_rec(i, $urandom_range(0, 1023), $urandom_range(0, 1023),
                      $urandom_range(1, 7), $urandom_range(0, 7));
        commit_req(2, 1'b0);
        clear_req();
        commit_req(4, 1'b0);
        check("clear mask zero", active_mask, '0);

        if (DBUF) begin
            // A vsync fall on the same edge that enters the wait is not taken.
            write_rec(2, 'h155, 'h2AA, 4, 1);
            @(negedge clk);
            to_hw_sig = 2'b10;
            frame_vs  = 1'b0;
            repeat (3) @(negedge clk);
            check("coincide rsp", to_sw_sig, 2'b00);
            check("coincide pending", commit_pending, 1'b1);
            check_live("coincide live");
            frame_vs = 1'b1;
            @(negedge clk);
            finish_commit("coincide");
        end

        for (int n = 0; n < 40; n++) begin
            int op = $urandom_range(0, 9);
            if (op <= 5) begin
                int idx = ($urandom_range(0, 7) == 0) ? $urandom_range(NS, 63) : $urandom_range(0, NS - 1);
                write_rec(idx, $urandom_range(0, 1023), $urandom_range(0, 1023),
                          $urandom_range(0, 7), $urandom_range(0, 7));
            end else if (op == 6) begin
                clear_req();
            end else begin
                commit_req($urandom_range(2, 8), 1'(($urandom_range(0, 1))));
            end
        end

        // Reset while a commit is outstanding.
        write_rec(5, 'h123, 'h321, 6, 2);
        commit_req(2, 1'b0);
        write_rec(6, 'h0AB, 'h0CD, 3, 4);
        @(negedge clk);
        to_hw_sig = 2'b10;
        repeat (DBUF ? 3 : 1) @(negedge clk);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check("midreset rsp", to_sw_sig, 2'b00);
        check("midreset pending", commit_pending, 1'b0);
        check("midreset mask", active_mask, '0);
        check_live("midreset");
        @(negedge clk);
        reset     = 1'b0;
        to_hw_sig = 2'b00;
        frame_vs  = 1'b0;
        repeat (4) @(negedge clk);
        check("postreset rsp", to_sw_sig, 2'b00);
        check_live("postreset");
        frame_vs = 1'b1;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
